// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the FSM state type, the forwarding select codes and the forwarding rule.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // EX/MEM result is younger than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_we && mem_rd != 5'd0 && mem_rd == src) begin
            sel = FWD_EXMEM;
        end else if (wb_we && wb_rd != 5'd0 && wb_rd == src) begin
            sel = FWD_MEMWB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Stage-field and pipeline-control bundle between the datapath (master)
// and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             ex_memread;
    logic             mem_regwrite;
    logic [4:0]       mem_rd;
    logic             wb_regwrite;
    logic [4:0]       wb_rd;
    logic             mem_req;
    logic             mem_ready;
    logic             branch_taken;
    logic             pc_we;
    logic             ifid_we;
    logic             idex_we;
    logic             exmem_we;
    logic             ifid_flush;
    logic             idex_flush;
    logic             memwb_bubble;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_memread,
               mem_regwrite, mem_rd, wb_regwrite, wb_rd,
               mem_req, mem_ready, branch_taken,
        input  pc_we, ifid_we, idex_we, exmem_we,
               ifid_flush, idex_flush, memwb_bubble,
               fwd_a, fwd_b, stall_cnt, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rs, ex_rt, ex_memread,
               mem_regwrite, mem_rd, wb_regwrite, wb_rd,
               mem_req, mem_ready, branch_taken,
        output pc_we, ifid_we, idex_we, exmem_we,
               ifid_flush, idex_flush, memwb_bubble,
               fwd_a, fwd_b, stall_cnt, mem_timeout
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// EX operand forwarding selects; purely combinational, one lane per operand.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       i_mem_regwrite,
    input  logic [4:0] i_mem_rd,
    input  logic       i_wb_regwrite,
    input  logic [4:0] i_wb_rd,
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_ex_rt,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);
    logic [4:0] w_src [2];
    logic [1:0] w_sel [2];

    assign w_src[0] = i_ex_rs;
    assign w_src[1] = i_ex_rt;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign w_sel[gi] = fwd_sel(i_mem_regwrite, i_mem_rd,
                                       i_wb_regwrite, i_wb_rd, w_src[gi]);
        end
    endgenerate

    assign o_fwd_a = w_sel[0];
    assign o_fwd_b = w_sel[1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: memory-wait freeze,
// branch flush, load-use bubble, forwarding, stall counter and memory timeout.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_timeout;

    logic       w_load_use;
    logic       w_freeze;
    logic       w_pc_we, w_ifid_we, w_idex_we, w_exmem_we;
    logic       w_ifid_flush, w_idex_flush, w_memwb_bubble;
    logic [1:0] w_fwd_a, w_fwd_b;

    assign w_load_use = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                        ((bus.ex_rt == bus.id_rs) ||
                         (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    // Once waiting, only mem_ready releases the freeze, whatever mem_req does.
    assign w_freeze = !bus.mem_ready &&
                      ((r_state == ST_MEM_WAIT) || bus.mem_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_RUN;
        if (w_freeze) begin
            w_state_next = ST_MEM_WAIT;
        end
    end

    always_comb begin
        w_pc_we        = 1'b1;
        w_ifid_we      = 1'b1;
        w_idex_we      = 1'b1;
        w_exmem_we     = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_memwb_bubble = 1'b0;
        if (rst) begin
            w_pc_we        = 1'b0;
            w_ifid_we      = 1'b0;
            w_idex_we      = 1'b0;
            w_exmem_we     = 1'b0;
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_memwb_bubble = 1'b1;
        end else if (w_freeze) begin
            w_pc_we        = 1'b0;
            w_ifid_we      = 1'b0;
            w_idex_we      = 1'b0;
            w_exmem_we     = 1'b0;
            w_memwb_bubble = 1'b1;
        end else if (bus.branch_taken) begin
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
        end else if (w_load_use) begin
            w_pc_we        = 1'b0;
            w_ifid_we      = 1'b0;
            w_idex_flush   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (!w_pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            // Counts MEM_WAIT cycles without ready; held at zero while running.
            if (r_state == ST_RUN) begin
                r_wait_cnt <= '0;
            end else if (!bus.mem_ready) begin
                if (r_wait_cnt != WAIT_MAX) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (r_wait_cnt >= WAIT_LAST) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    fwd_unit u_fwd (
        .i_mem_regwrite (bus.mem_regwrite),
        .i_mem_rd       (bus.mem_rd),
        .i_wb_regwrite  (bus.wb_regwrite),
        .i_wb_rd        (bus.wb_rd),
        .i_ex_rs        (bus.ex_rs),
        .i_ex_rt        (bus.ex_rt),
        .o_fwd_a        (w_fwd_a),
        .o_fwd_b        (w_fwd_b)
    );

    assign bus.pc_we        = w_pc_we;
    assign bus.ifid_we      = w_ifid_we;
    assign bus.idex_we      = w_idex_we;
    assign bus.exmem_we     = w_exmem_we;
    assign bus.ifid_flush   = w_ifid_flush;
    assign bus.idex_flush   = w_idex_flush;
    assign bus.memwb_bubble = w_memwb_bubble;
    assign bus.fwd_a        = rst ? FWD_RF : w_fwd_a;
    assign bus.fwd_b        = rst ? FWD_RF : w_fwd_b;
    assign bus.stall_cnt    = r_stall_cnt;
    assign bus.mem_timeout  = r_timeout;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized checks of pipe_hazard_ctrl against a cycle-level
// behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Model state: waiting or not, how long, stall total, sticky timeout.
    bit m_wait    = 1'b0;
    int m_waited  = 0;
    int m_stall   = 0;
    bit m_timeout = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fwd_ref(input logic [4:0] src);
        if (bus.mem_regwrite && bus.mem_rd != 0 && bus.mem_rd == src) return 2;
        if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == src) return 1;
        return 0;
    endfunction

    task automatic idle();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rt = 0;
        bus.ex_rs = 0; bus.ex_rt = 0; bus.ex_memread = 0;
        bus.mem_regwrite = 0; bus.mem_rd = 0;
        bus.wb_regwrite = 0; bus.wb_rd = 0;
        bus.mem_req = 0; bus.mem_ready = 1; bus.branch_taken = 0;
    endtask

    // One cycle: inputs are already driven at the falling edge.
    task automatic step(input string tag);
        bit frozen, lu;
        int e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf, e_bub, e_fa, e_fb;
        #1;
        frozen = !bus.mem_ready && (m_wait || bus.mem_req);
        lu = bus.ex_memread && bus.ex_rt != 0 &&
             (bus.ex_rt == bus.id_rs || (bus.id_uses_rt && bus.ex_rt == bus.id_rt));
        e_fa = fwd_ref(bus.ex_rs);
        e_fb = fwd_ref(bus.ex_rt);
        {e_pc, e_ifid, e_idex, e_exmem, e_iff, e_idf, e_bub} = {7{32'd0}};
        if (rst) begin
            e_iff = 1; e_idf = 1; e_bub = 1; e_fa = 0; e_fb = 0;
        end else if (frozen) begin
            e_bub = 1;
        end else begin
            e_pc = 1; e_ifid = 1; e_idex = 1; e_exmem = 1;
            if (bus.branch_taken) begin
                e_iff = 1; e_idf = 1;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_idf = 1;
            end
        end
        chk({tag, ".pc_we"},        32'(bus.pc_we),        e_pc);
        chk({tag, ".ifid_we"},      32'(bus.ifid_we),      e_ifid);
        chk({tag, ".idex_we"},      32'(bus.idex_we),      e_idex);
        chk({tag, ".exmem_we"},     32'(bus.exmem_we),     e_exmem);
        chk({tag, ".ifid_flush"},   32'(bus.ifid_flush),   e_iff);
        chk({tag, ".idex_flush"},   32'(bus.idex_flush),   e_idf);
        chk({tag, ".memwb_bubble"}, 32'(bus.memwb_bubble), e_bub);
        chk({tag, ".fwd_a"},        32'(bus.fwd_a),        e_fa);
        chk({tag, ".fwd_b"},        32'(bus.fwd_b),        e_fb);
        @(posedge clk);
        if (rst) begin
            m_wait = 0; m_waited = 0; m_stall = 0; m_timeout = 0;
        end else begin
            if (e_pc == 0 && m_stall < CNT_SAT) m_stall++;
            if (m_wait && !bus.mem_ready) begin
                m_waited++;
                if (m_waited >= MAX_WAIT) m_timeout = 1;
            end else begin
                m_waited = 0;
            end
            m_wait = frozen;
        end
        @(negedge clk);
        chk({tag, ".stall_cnt"},   32'(bus.stall_cnt),   m_stall);
        chk({tag, ".mem_timeout"}, 32'(bus.mem_timeout), 32'(m_timeout));
        $display("step %-12s rst=%0b req=%0b rdy=%0b br=%0b pc_we=%0b flush=%0b%0b bub=%0b fwd=%0b/%0b stall=%0d tmo=%0b",
                 tag, rst, bus.mem_req, bus.mem_ready, bus.branch_taken, e_pc, e_iff, e_idf,
                 e_bub, 2'(e_fa), 2'(e_fb), m_stall, m_timeout);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        step("reset");
        step("reset");
        rst = 1'b0;

        bus.ex_memread = 1; bus.ex_rt = 5; bus.id_rs = 5;
        step("load_use");
        chk("lu.stall_is_1", 32'(bus.stall_cnt), 1);
        idle();
        step("lu_clear");

        bus.ex_memread = 1; bus.ex_rt = 7; bus.id_rt = 7; bus.id_uses_rt = 1;
        bus.branch_taken = 1;
        step("br_lu");
        chk("br_lu.stall_same", 32'(bus.stall_cnt), 1);
        idle();

        bus.mem_req = 1; bus.mem_ready = 0;
        repeat (3) step("mem_wait");
        bus.mem_ready = 1;
        step("mem_ready");
        bus.mem_req = 0; bus.mem_ready = 0;
        step("run_probe");
        chk("memwait.stall_is_4", 32'(bus.stall_cnt), 4);
        idle();

        bus.mem_req = 1; bus.mem_ready = 0; bus.branch_taken = 1;
        repeat (2) step("br_in_wait");
        bus.mem_ready = 1;
        step("br_release");
        idle();

        bus.mem_req = 1; bus.mem_ready = 0;
        repeat (6) step("timeout");
        bus.mem_ready = 1;
        step("to_ready");
        idle();
        step("to_sticky");
        chk("timeout.sticky", 32'(bus.mem_timeout), 1);

        bus.mem_regwrite = 1; bus.mem_rd = 8; bus.wb_regwrite = 1; bus.wb_rd = 8;
        bus.ex_rs = 8; bus.ex_rt = 0;
        step("fwd_exmem");
        bus.mem_rd = 0;
        step("fwd_memwb");
        idle();

        bus.mem_req = 1; bus.mem_ready = 0;
        repeat (2) step("pre_rst");
        rst = 1'b1;
        step("rst_in_wait");
        rst = 1'b0;
        bus.mem_req = 0;
        step("post_rst");
        idle();

        for (int n = 0; n < 400; n++) begin
            rst              = ($urandom_range(0, 63) == 0);
            bus.id_rs        = 5'($urandom_range(0, 3));
            bus.id_rt        = 5'($urandom_range(0, 3));
            bus.id_uses_rt   = 1'($urandom);
            bus.ex_rs        = 5'($urandom_range(0, 3));
            bus.ex_rt        = 5'($urandom_range(0, 3));
            bus.ex_memread   = 1'($urandom);
            bus.mem_regwrite = 1'($urandom);
            bus.mem_rd       = 5'($urandom_range(0, 3));
            bus.wb_regwrite  = 1'($urandom);
            bus.wb_rd        = 5'($urandom_range(0, 3));
            bus.mem_req      = ($urandom_range(0, 2) == 0);
            bus.mem_ready    = ($urandom_range(0, 3) != 0);
            bus.branch_taken = ($urandom_range(0, 4) == 0);
            step("random");
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
